mips_cpu_mem_arbiter: RTL and testbench
=======================================

# mips_cpu_mem_arbiter

Arbiter that shares one memory-mapped bus (waitrequest protocol) between the CPU's instruction-fetch port and data port. It sits between the multicycle core and a unified memory. Each transfer is registered at grant and held stable on the bus until the slave releases `waitrequest`. Data accesses take priority, and a starvation counter guarantees forward progress for fetches.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive data grants allowed while a fetch is pending; the next grant then goes to the fetch.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `i_read`  in  1  instruction fetch request
- `i_address`  in  32  fetch byte address
- `i_readdata`  out  32  fetched word
- `i_waitrequest`  out  1  high until the fetch completes
- `d_read` / `d_write`  in  1 each  data read / write request
- `d_address`  in  32  data byte address
- `d_writedata`  in  32  store data
- `d_byteenable`  in  4  store/load lane enables
- `d_readdata`  out  32  load data
- `d_waitrequest`  out  1  high until the data access completes
- `address`  out  32  bus address
- `read` / `write`  out  1 each  bus strobes
- `writedata`  out  32  bus store data
- `byteenable`  out  4  bus lane enables
- `readdata`  in  32  bus read data
- `waitrequest`  in  1  slave stall

## Operation
- States:
  - IDLE: no transfer active; arbitrates this cycle.
  - INSTR: fetch active on bus.
  - DATA: data access active on bus.
- Any request in IDLE causes a grant at the clock edge:
  - Chosen requester's address, writedata, byteenable and op are latched into bus output registers.
  - State moves to INSTR or DATA.
- Grant choice:
  - Data request wins, unless `starve_cnt == STARVE_LIMIT` and `i_read` is high; the fetch then wins.
  - `starve_cnt` increments on each data grant while `i_read` is high and saturates at `STARVE_LIMIT`.
  - `starve_cnt` clears on every instruction grant, and on any data grant while `i_read` is low.
- `d_read` and `d_write` both high: treated as a write (protocol error; no flag).
- In INSTR/DATA:
  - Bus outputs hold their latched values while `waitrequest` is high.
  - On the first cycle with `waitrequest` low, the transfer completes: the granted requester's `*_waitrequest` drops for exactly that cycle, `*_readdata = readdata` (combinational pass-through), strobes clear at the edge, and state returns to IDLE.
- Fetches are always `read` with `byteenable = 4'hF`.
- Requesters must hold their request until they see their `*_waitrequest` low. A request dropped mid-transfer does not abort the bus transfer; the result is discarded.
- `*_waitrequest` is high whenever that requester is not completing, including IDLE, wait states, and while the other requester is served.
- Reset values:
  - state IDLE, `starve_cnt` 0
  - `read`/`write` 0, `address`/`writedata` 0, `byteenable` 0
  - `i_waitrequest` = `d_waitrequest` = 1, `i_readdata` = `d_readdata` = 0
- Reset mid-transfer: the transfer is abandoned. Strobes are 0 on the cycle after the reset edge. No completion is signalled.

## Timing
- Minimum latency: request seen in IDLE at edge N; bus strobe valid in cycle N+1; completion in cycle N+1 if the slave has zero wait states; the requester's `waitrequest` is low in N+1.
- Mandatory IDLE cycle between back-to-back transfers, so the peak rate is one transfer per 2 cycles.
- Wait states extend INSTR/DATA one cycle per cycle of `waitrequest` high; no timeout.
- A request arriving during an active transfer is not granted before the next IDLE cycle.
- `starve_cnt` width: `$clog2(STARVE_LIMIT+1)`.

## Structure
- Shared package `mips_cpu_pkg`:
  - `arb_state_t` enum (IDLE, INSTR, DATA).
  - Bus-width constants (`ADDR_W` = 32, `DATA_W` = 32, `BE_W` = 4).
- Single flat module; no sub-module. The priority/starvation logic is a few lines of a combinational grant decode plus the counter register.

## Test plan
- Fetch only, zero-wait slave, `i_address` = 0xBFC00000 → `read` = 1 with `address` = 0xBFC00000 in cycle N+1; `i_waitrequest` low in N+1; `i_readdata` = slave word.
- Simultaneous fetch and data write (`d_address` = 0x100, data 0xDEADBEEF, be = 4'b0011) → data granted first with `write` = 1 and `byteenable` = 4'b0011; fetch granted after the IDLE gap.
- `STARVE_LIMIT` = 4, `d_read` and `i_read` held continuously → 4 data completions, then 1 fetch, repeating.
- Slave holds `waitrequest` for 3 cycles → bus outputs stable for all 4 cycles; requester `waitrequest` low only in the 4th.
- `reset` asserted in the second wait cycle of a data write → next cycle `write` = 0, state IDLE, `d_waitrequest` = 1, `starve_cnt` = 0.
- `d_read` and `d_write` both high → bus `write` = 1, `read` = 0.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared types and bus-width constants for the MIPS CPU memory subsystem.
package mips_cpu_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mips_cpu_mem_arbiter.sv
// Shares one waitrequest-style memory bus between the instruction-fetch and data
// ports; data has priority, a saturating counter guarantees fetch progress.
module mips_cpu_mem_arbiter
  import mips_cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_waitrequest,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  input  logic [BE_W-1:0]   d_byteenable,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_waitrequest,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic [BE_W-1:0]   byteenable,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic [BE_W-1:0]   byteenable_q, byteenable_d;
  logic              read_q, read_d;
  logic              write_q, write_d;

  logic d_req;
  logic fetch_forced;
  logic i_done;
  logic d_done;

  assign d_req        = d_read | d_write;
  assign fetch_forced = i_read && (starve_cnt_q == LIMIT_C);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    read_d       = read_q;
    write_d      = write_q;
    case (state_q)
      IDLE: begin
        if (d_req && !fetch_forced) begin
          state_d      = DATA;
          address_d    = d_address;
          writedata_d  = d_writedata;
          byteenable_d = d_byteenable;
          // Read and write together is a requester error; the write wins.
          write_d      = d_write;
          read_d       = ~d_write;
          if (!i_read) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != LIMIT_C) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end else begin
            starve_cnt_d = starve_cnt_q;
          end
        end else if (i_read) begin
          state_d      = INSTR;
          address_d    = i_address;
          writedata_d  = '0;
          byteenable_d = 4'hF;
          read_d       = 1'b1;
          write_d      = 1'b0;
          starve_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      INSTR, DATA: begin
        if (!waitrequest) begin
          state_d = IDLE;
          read_d  = 1'b0;
          write_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      read_q       <= read_d;
      write_q      <= write_d;
    end
  end

  // Completion is the first slave-ready cycle of a transfer; never while in reset.
  assign i_done = (state_q == INSTR) && !waitrequest && !reset;
  assign d_done = (state_q == DATA)  && !waitrequest && !reset;

  assign i_waitrequest = ~i_done;
  assign d_waitrequest = ~d_done;
  assign i_readdata    = i_done ? readdata : '0;
  assign d_readdata    = d_done ? readdata : '0;

  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Randomized scoreboard bench for mips_cpu_mem_arbiter with a transaction-level
// reference model of grant order, bus contents and requester completion.
module tb_mips_cpu_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_readdata;
  logic        i_waitrequest;
  logic        d_read, d_write;
  logic [31:0] d_address, d_writedata, d_readdata;
  logic [3:0]  d_byteenable;
  logic        d_waitrequest;
  logic [31:0] address, writedata, readdata;
  logic        read, write;
  logic [3:0]  byteenable;
  logic        waitrequest;

  mips_cpu_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata),
    .i_waitrequest(i_waitrequest),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    logic [31:0] addr;
    bit          wr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t cur;
  bit    order_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    mon_en = 1'b0, in_xfer = 1'b0, log_order = 1'b0;
  bit    i_done = 1'b0, d_done = 1'b0;
  bit    model_busy = 1'b0;
  int    starve = 0;
  int    i_age = 0, d_age = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Reference model: one arbitration per free bus cycle, then busy until the slave is ready.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      model_busy = 1'b0;
      starve     = 0;
      exp_q.delete();
    end else if (model_busy) begin
      if (!waitrequest) model_busy = 1'b0;
    end else if (d_read || d_write || i_read) begin
      xfer_t x;
      if ((d_read || d_write) && !(i_read && starve == LIMIT)) begin
        x.is_data = 1'b1; x.addr = d_address; x.wr = d_write;
        x.be = d_byteenable; x.wdata = d_writedata;
        starve = i_read ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
      end else begin
        x.is_data = 1'b0; x.addr = i_address; x.wr = 1'b0;
        x.be = 4'hF; x.wdata = 32'd0;
        starve = 0;
      end
      exp_q.push_back(x);
      model_busy = 1'b1;
    end
  end

  // Monitor: pops an expectation at each transfer start and checks hold/completion.
  initial forever begin
    @(negedge clk);
    if (!mon_en) begin
      in_xfer = 1'b0;
    end else if (read || write) begin
      if (!in_xfer) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_grant: bus strobe at %h, expected no transfer", address);
          cur.is_data = write; cur.addr = address; cur.wr = write;
          cur.be = byteenable; cur.wdata = writedata;
        end else begin
          cur = exp_q.pop_front();
          chk("grant_addr", address, cur.addr);
          chk1("grant_write", write, cur.wr);
          chk1("grant_read", read, !cur.wr);
          chk("grant_be", {28'd0, byteenable}, {28'd0, cur.be});
          if (cur.wr) chk("grant_wdata", writedata, cur.wdata);
          if (log_order) order_q.push_back(cur.is_data);
        end
        in_xfer = 1'b1;
      end else begin
        chk("hold_addr", address, cur.addr);
        chk("hold_be", {28'd0, byteenable}, {28'd0, cur.be});
        chk1("hold_write", write, cur.wr);
        chk1("hold_read", read, !cur.wr);
      end
      if (!waitrequest) begin
        chk1("i_waitrequest_done", i_waitrequest, cur.is_data);
        chk1("d_waitrequest_done", d_waitrequest, !cur.is_data);
        if (!cur.wr) begin
          if (cur.is_data) chk("d_readdata", d_readdata, readdata);
          else             chk("i_readdata", i_readdata, readdata);
        end
        if (cur.is_data) d_done = 1'b1;
        else             i_done = 1'b1;
        in_xfer = 1'b0;
      end else begin
        chk1("i_waitrequest_stall", i_waitrequest, 1'b1);
        chk1("d_waitrequest_stall", d_waitrequest, 1'b1);
      end
    end else begin
      if (in_xfer) begin
        n_cmp++; n_bad++;
        $display("FAIL strobe_dropped: strobes low at %h, expected transfer held", address);
      end
      in_xfer = 1'b0;
      chk1("i_waitrequest_idle", i_waitrequest, 1'b1);
      chk1("d_waitrequest_idle", d_waitrequest, 1'b1);
    end
  end

  // One cycle of random requesters and slave; requests persist until completed.
  task automatic drive_cycle(input bit allow_new);
    int op;
    waitrequest = ($urandom_range(0, 1) == 1);
    readdata    = $urandom;
    if (i_read) begin
      if (i_done) begin
        i_read = 1'b0;
      end else begin
        i_age++;
        if (i_age == 200) begin
          n_cmp++; n_bad++;
          $display("FAIL fetch_progress: waited %0d cycles, expected under 200", i_age);
        end
      end
    end
    if (!i_read && allow_new && $urandom_range(0, 2) == 0) begin
      i_read = 1'b1; i_address = $urandom & 32'hFFFF_FFFC; i_age = 0; i_done = 1'b0;
    end
    if (d_read || d_write) begin
      if (d_done) begin
        d_read = 1'b0; d_write = 1'b0;
      end else begin
        d_age++;
        if (d_age == 200) begin
          n_cmp++; n_bad++;
          $display("FAIL data_progress: waited %0d cycles, expected under 200", d_age);
        end
      end
    end
    if (!(d_read || d_write) && allow_new && $urandom_range(0, 1) == 0) begin
      op = $urandom_range(0, 3);
      d_read = (op == 0 || op == 2);
      d_write = (op != 0);
      d_address = $urandom & 32'hFFFF_FFFC;
      d_writedata = $urandom;
      d_byteenable = 4'($urandom_range(0, 15));
      d_age = 0; d_done = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; i_read = 1'b0; i_address = 32'd0;
    d_read = 1'b0; d_write = 1'b0; d_address = 32'd0;
    d_writedata = 32'd0; d_byteenable = 4'd0;
    readdata = 32'd0; waitrequest = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_read", read, 1'b0);
    chk1("rst_write", write, 1'b0);
    chk("rst_address", address, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_be", {28'd0, byteenable}, 32'd0);
    chk1("rst_i_wait", i_waitrequest, 1'b1);
    chk1("rst_d_wait", d_waitrequest, 1'b1);
    chk("rst_i_rdata", i_readdata, 32'd0);
    chk("rst_d_rdata", d_readdata, 32'd0);

    // Fetch only, zero-wait slave: completes in the cycle after the grant edge.
    @(posedge clk); #2;
    reset = 1'b0; mon_en = 1'b1;
    i_read = 1'b1; i_address = 32'hBFC0_0000; waitrequest = 1'b0; readdata = 32'h2408_0001;
    @(negedge clk);
    @(negedge clk);
    chk1("fetch_read", read, 1'b1);
    chk("fetch_addr", address, 32'hBFC0_0000);
    chk1("fetch_wait_low", i_waitrequest, 1'b0);
    chk("fetch_rdata", i_readdata, 32'h2408_0001);
    @(posedge clk); #2;
    i_read = 1'b0; i_done = 1'b0;

    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #2;
      drive_cycle(1'b1);
    end
    for (int c = 0; c < 300 && (i_read || d_read || d_write || model_busy); c++) begin
      @(posedge clk); #2;
      drive_cycle(1'b0);
    end
    chk1("drain_complete", i_read || d_read || d_write, 1'b0);

    // Reset during the second wait cycle of a data write abandons the transfer.
    @(posedge clk); #2;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b1; d_address = 32'h100;
    d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'b0011; waitrequest = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b1; mon_en = 1'b0; d_write = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk1("rst_mid_write", write, 1'b0);
    chk1("rst_mid_read", read, 1'b0);
    chk1("rst_mid_d_wait", d_waitrequest, 1'b1);
    chk1("rst_mid_i_wait", i_waitrequest, 1'b1);
    chk("rst_mid_address", address, 32'd0);
    d_done = 1'b0; i_done = 1'b0; mon_en = 1'b1;

    // Both requesters held continuously with a zero-wait slave: D D D D I repeating.
    @(posedge clk); #2;
    log_order = 1'b1; waitrequest = 1'b0;
    i_read = 1'b1; i_address = 32'hBFC0_0000;
    d_write = 1'b1; d_address = 32'h100; d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'b0011;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #2;
      i_done = 1'b0; d_done = 1'b0;
      readdata = $urandom;
    end
    i_read = 1'b0; d_write = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    log_order = 1'b0;
    chk1("order_len", order_q.size() >= 20, 1'b1);
    for (int k = 0; k < 20 && k < order_q.size(); k++) begin
      chk1($sformatf("order_%0d", k), order_q[k], (k % 5) != 4);
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
